// File: rtl/event_pkg.sv
// rtl/event_pkg.sv - shared event-path constants and timestamp word type
package event_pkg;

   localparam int TS_W_DEF       = 32;
   localparam int DEPTH_LOG2_DEF = 4;
   localparam int DROP_CNT_W     = 16;

   typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/event_ts_fifo_ts_counter.sv
// rtl/event_ts_fifo_ts_counter.sv - free-running wrapping timestamp counter (module ts_counter)
module ts_counter
   import event_pkg::*;
#(
   parameter int TS_W = TS_W_DEF
)
(
   input  logic            clk,
   input  logic            rst,
   output logic [TS_W-1:0] ts
);

   logic [TS_W-1:0] r_ts;

   // count every non-reset cycle, silently wrapping at the top
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
      end
   end

   assign ts = r_ts;

endmodule

// File: rtl/event_ts_fifo.sv
// rtl/event_ts_fifo.sv - timestamp FIFO behind the event trigger; optional EVENT_TS_FIFO_DROP_CNT_EN adds drop_cnt
module event_ts_fifo
   import event_pkg::*;
#(
   parameter int TS_W       = TS_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wtreq,
   output logic                  wtfull,
   input  logic                  rdreq,
   output logic                  rdempty,
   output logic [TS_W-1:0]       rdata,
   output logic                  rdvalid,
   output logic [DEPTH_LOG2:0]   count
`ifdef EVENT_TS_FIFO_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   localparam int                  DEPTH     = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [TS_W-1:0]       r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [TS_W-1:0]       r_rdata;
   logic                  r_rdvalid;

   logic [TS_W-1:0]       w_ts;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   ts_counter #(.TS_W(TS_W)) u_ts (
      .clk (clk),
      .rst (rst),
      .ts  (w_ts)
   );

   // flags come only from registered count, so both see pre-edge state
   assign w_full   = (r_count == DEPTH_CNT);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = wtreq && !w_full;
   assign w_rd_acc = rdreq && !w_empty;

   // storage array; no reset, contents are meaningless until written
   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc) begin
         r_mem[r_wptr] <= w_ts;
      end
   end

   // pointers, occupancy and the registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_rdata   <= '0;
         r_rdvalid <= 1'b0;
      end else begin
         r_rdvalid <= w_rd_acc;
         if (w_wr_acc) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rdata <= r_mem[r_rptr];
            r_rptr  <= r_rptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef EVENT_TS_FIFO_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   // count rejected writes, sticking at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (wtreq && w_full && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
         r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign wtfull  = w_full;
   assign rdempty = w_empty;
   assign rdata   = r_rdata;
   assign rdvalid = r_rdvalid;
   assign count   = r_count;

endmodule
